// File: rtl/xnormaj_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : xnormaj_seq_ctrl
// Brief    : Runs one M-bit XNOR-popcount-majority stage over K chunks, one
//            chunk per cycle, and reports the majority of chunk majorities.
// Revision : 1.0 - initial release
// ============================================================================
module xnormaj_seq_ctrl #(
    parameter int M      = 3,
    parameter int K      = 5,
    parameter int M_LOG2 = $clog2(M + 1),
    parameter int K_LOG2 = $clog2(K + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [M*K-1:0]    a,
    input  logic [M*K-1:0]    w,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_m,
    output logic [K_LOG2-1:0] out_votes
);

    // Chunk index needs at least one bit even when K == 1.
    localparam int IDX_W = (K > 1) ? $clog2(K) : 1;

    localparam logic [1:0] c_idle = 2'd0;
    localparam logic [1:0] c_run  = 2'd1;
    localparam logic [1:0] c_done = 2'd2;

    localparam logic [IDX_W-1:0]  c_last  = IDX_W'(K - 1);
    localparam logic [M_LOG2-1:0] c_mhalf = M_LOG2'((M - 1) / 2);
    localparam logic [K_LOG2-1:0] c_khalf = K_LOG2'((K - 1) / 2);

    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;
    logic [M*K-1:0]    r_a;
    logic [M*K-1:0]    r_w;
    logic [IDX_W-1:0]  r_idx;
    logic [K_LOG2-1:0] r_votes;

    logic [M-1:0]      w_ca;
    logic [M-1:0]      w_cw;
    logic [M-1:0]      w_x;
    logic [M_LOG2-1:0] w_pop;
    logic              w_vote;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_idle;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_idle:  if (in_valid) w_state_nxt = c_run;
            c_run:   if (r_idx == c_last) w_state_nxt = c_done;
            c_done:  if (out_ready) w_state_nxt = c_idle;
            default: w_state_nxt = c_idle;
        endcase
    end

    always_comb begin
        in_ready  = (r_state == c_idle);
        out_valid = (r_state == c_done);
        out_votes = out_valid ? r_votes : '0;
        out_m     = out_valid && (r_votes > c_khalf);
    end

    // Current chunk's agreement count and its majority vote.
    assign w_ca = r_a[M*int'(r_idx) +: M];
    assign w_cw = r_w[M*int'(r_idx) +: M];
    assign w_x  = w_ca ~^ w_cw;

    always_comb begin
        w_pop = '0;
        for (int i = 0; i < M; i++) begin
            w_pop = w_pop + M_LOG2'(w_x[i]);
        end
    end

    assign w_vote = (w_pop > c_mhalf);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_a     <= '0;
            r_w     <= '0;
            r_idx   <= '0;
            r_votes <= '0;
        end else begin
            case (r_state)
                c_idle: begin
                    if (in_valid) begin
                        r_a     <= a;
                        r_w     <= w;
                        r_idx   <= '0;
                        r_votes <= '0;
                    end
                end
                c_run: begin
                    r_votes <= r_votes + K_LOG2'(w_vote);
                    if (r_idx != c_last) begin
                        r_idx <= r_idx + IDX_W'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire
